muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide controller that replaces the two-cycle multiply path feeding the HI/LO registers.

---
 rtl/muldiv_sequencer.sv | 153 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer feeding HI/LO: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with fixed WIDTH+3 cycle latency from Start to Done.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             Flush,
    input  logic             HiLoRead,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             HiLoWrite,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut,
    output logic             DivByZero
);

    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t             state, state_next;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, mag_a, mag_b;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q, neg_r, dbz_q;

    logic               is_div, is_signed, accept, last_iter;
    logic [WIDTH-1:0]   abs_a, abs_b, quo_raw, rem_raw, quo_fix, rem_fix;
    logic [WIDTH:0]     mul_addend, mul_sum, div_shift, div_trial;
    logic [ACC_W-1:0]   prod_fix;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign accept    = Start && !Flush;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    assign Busy      = (state == PREP) || (state == CALC) || (state == FIX);
    assign Stall     = Busy && (Start || HiLoRead);
    assign Done      = (state == DONE);
    assign HiLoWrite = Done;

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; Flush aborts any busy state, the exit from CALC depends on cnt only
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = accept ? PREP : IDLE;
            PREP:       state_next = Flush ? IDLE : CALC;
            CALC: begin
                if (Flush)          state_next = IDLE;
                else if (last_iter) state_next = FIX;
            end
            FIX:        state_next = Flush ? IDLE : DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Iteration and sign-correction arithmetic
    always_comb begin
        abs_a      = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        abs_b      = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        mul_addend = mag_b[0] ? {1'b0, mag_a} : (WIDTH + 1)'(0);
        mul_sum    = {1'b0, acc[ACC_W-1:WIDTH]} + mul_addend;
        div_shift  = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
        div_trial  = div_shift - {1'b0, mag_b};
        quo_raw    = acc[WIDTH-1:0];
        rem_raw    = acc[ACC_W-1:WIDTH];
        quo_fix    = neg_q ? -quo_raw : quo_raw;
        rem_fix    = neg_r ? -rem_raw : rem_raw;
        prod_fix   = neg_q ? -acc : acc;
    end

    // Datapath; results land in HiOut/LoOut on the FIX->DONE edge only
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            op_q      <= 2'b00;
            a_q       <= '0;
            b_q       <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dbz_q     <= 1'b0;
            HiOut     <= '0;
            LoOut     <= '0;
            DivByZero <= 1'b0;
        end else begin
            DivByZero <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q <= Op;
                        a_q  <= OperandA;
                        b_q  <= OperandB;
                    end
                end
                PREP: begin
                    neg_q <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_r <= is_signed && is_div && a_q[WIDTH-1];
                    dbz_q <= is_div && (b_q == '0);
                    mag_a <= abs_a;
                    mag_b <= abs_b;
                    acc   <= is_div ? {WIDTH'(0), abs_a} : ACC_W'(0);
                    cnt   <= '0;
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        if (!div_trial[WIDTH])
                            acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end else begin
                        acc   <= {mul_sum, acc[WIDTH-1:1]};
                        mag_b <= mag_b >> 1;
                    end
                end
                FIX: begin
                    if (!Flush) begin
                        if (is_div && dbz_q) begin
                            HiOut     <= a_q;
                            LoOut     <= '1;
                            DivByZero <= 1'b1;
                        end else if (is_div) begin
                            HiOut <= rem_fix;
                            LoOut <= quo_fix;
                        end else begin
                            HiOut <= prod_fix[ACC_W-1:WIDTH];
                            LoOut <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, flush, stall and reset behaviour.
module tb_muldiv_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    logic             Clk = 1'b0;
    logic             Reset, Start, Flush, HiLoRead;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OperandA, OperandB;
    logic             Busy, Stall, Done, HiLoWrite, DivByZero;
    logic [WIDTH-1:0] HiOut, LoOut;

    int checks = 0;
    int failures = 0;

    // Observations gathered by run_op
    int               r_done_cnt, r_done_cyc, r_dbz_cnt, r_busy_err, r_hlw_err;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             r_dbz;

    muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush), .HiLoRead(HiLoRead),
        .Busy(Busy), .Stall(Stall), .Done(Done), .HiLoWrite(HiLoWrite),
        .HiOut(HiOut), .LoOut(LoOut), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Issue one op in cycle 0 and observe 40 cycles
    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        r_done_cnt = 0; r_done_cyc = -1; r_dbz_cnt = 0; r_busy_err = 0; r_hlw_err = 0;
        r_hi = '0; r_lo = '0; r_dbz = 1'b0;
        step();
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        for (int c = 0; c < 40; c++) begin
            if (c == 1) Start = 1'b0;
            @(negedge Clk);
            if (Busy !== ((c >= 1) && (c <= 34))) r_busy_err++;
            if (HiLoWrite !== Done) r_hlw_err++;
            if (DivByZero === 1'b1) r_dbz_cnt++;
            if (Done === 1'b1) begin
                r_done_cnt++; r_done_cyc = c; r_hi = HiOut; r_lo = LoOut; r_dbz = DivByZero;
            end
            step();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b1; Flush = 1'b0; HiLoRead = 1'b1;
        Op = OP_MULT; OperandA = 32'h5; OperandB = 32'h6;
        step(); step();
        @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", Busy); end
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %b exp 0", Stall); end
        checks++; if (Done !== 1'b0 || HiLoWrite !== 1'b0) begin failures++; $display("FAIL reset_done got %b/%b exp 0/0", Done, HiLoWrite); end
        checks++; if (HiOut !== 32'h0 || LoOut !== 32'h0) begin failures++; $display("FAIL reset_hilo got %h/%h exp 0/0", HiOut, LoOut); end
        checks++; if (DivByZero !== 1'b0) begin failures++; $display("FAIL reset_dbz got %b exp 0", DivByZero); end
        step();
        Start = 1'b0; HiLoRead = 1'b0; Reset = 1'b1;
        step();
    endtask

    task automatic test_mult();
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        checks++; if (r_done_cnt !== 1 || r_done_cyc !== 35) begin failures++; $display("FAIL mult_latency got cnt=%0d cyc=%0d exp cnt=1 cyc=35", r_done_cnt, r_done_cyc); end
        checks++; if (r_hi !== 32'hFFFF_FFFF || r_lo !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_result got %h_%h exp ffffffff_ffffffeb", r_hi, r_lo); end
        checks++; if (r_busy_err !== 0) begin failures++; $display("FAIL mult_busy_window got %0d bad cycles exp 0", r_busy_err); end
        checks++; if (r_hlw_err !== 0) begin failures++; $display("FAIL mult_hilowrite got %0d bad cycles exp 0", r_hlw_err); end
    endtask

    task automatic test_multu();
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (r_done_cyc !== 35) begin failures++; $display("FAIL multu_latency got %0d exp 35", r_done_cyc); end
        checks++; if (r_hi !== 32'hFFFF_FFFE || r_lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_result got %h_%h exp fffffffe_00000001", r_hi, r_lo); end
        checks++; if (r_dbz_cnt !== 0) begin failures++; $display("FAIL multu_dbz got %0d exp 0", r_dbz_cnt); end
    endtask

    task automatic test_div();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        checks++; if (r_lo !== 32'hFFFF_FFFD || r_hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_signed got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", r_hi, r_lo); end
        run_op(OP_DIVU, 32'd7, 32'd2);
        checks++; if (r_lo !== 32'd3 || r_hi !== 32'd1) begin failures++; $display("FAIL divu got hi=%h lo=%h exp hi=1 lo=3", r_hi, r_lo); end
        checks++; if (r_done_cyc !== 35 || r_busy_err !== 0) begin failures++; $display("FAIL divu_latency got cyc=%0d busyerr=%0d exp 35/0", r_done_cyc, r_busy_err); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        checks++; if (r_lo !== 32'h8000_0000 || r_hi !== 32'h0) begin failures++; $display("FAIL div_overflow got hi=%h lo=%h exp hi=0 lo=80000000", r_hi, r_lo); end
        run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9);
        checks++; if (r_lo !== 32'hFFFF_FFF2 || r_hi !== 32'd2) begin failures++; $display("FAIL div_neg_divisor got hi=%h lo=%h exp hi=2 lo=fffffff2", r_hi, r_lo); end
    endtask

    task automatic test_div_zero();
        run_op(OP_DIV, 32'h0000_1234, 32'h0);
        checks++; if (r_done_cyc !== 35 || r_done_cnt !== 1) begin failures++; $display("FAIL dbz_latency got cyc=%0d cnt=%0d exp 35/1", r_done_cyc, r_done_cnt); end
        checks++; if (r_hi !== 32'h0000_1234 || r_lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dbz_result got hi=%h lo=%h exp hi=1234 lo=ffffffff", r_hi, r_lo); end
        checks++; if (r_dbz !== 1'b1 || r_dbz_cnt !== 1) begin failures++; $display("FAIL dbz_flag got %b cnt=%0d exp 1/1", r_dbz, r_dbz_cnt); end
    endtask

    // Runs right after test_div_zero, so HI/LO hold 0x1234/0xFFFFFFFF
    task automatic test_flush();
        int done_cnt = 0;
        int done_cyc = -1;
        logic [WIDTH-1:0] hi_s = '0, lo_s = '0;
        step();
        Start = 1'b1; Op = OP_MULT; OperandA = 32'd5; OperandB = 32'd6;
        for (int c = 0; c < 52; c++) begin
            if (c == 1)  Start = 1'b0;
            if (c == 10) Flush = 1'b1;
            if (c == 11) begin Flush = 1'b0; Start = 1'b1; Op = OP_DIVU; OperandA = 32'd100; OperandB = 32'd7; end
            if (c == 12) Start = 1'b0;
            @(negedge Clk);
            if (c == 11) begin
                checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL flush_busy got %b exp 0", Busy); end
            end
            if (c == 20) begin
                checks++; if (HiOut !== 32'h0000_1234 || LoOut !== 32'hFFFF_FFFF) begin failures++; $display("FAIL flush_hold got %h/%h exp 00001234/ffffffff", HiOut, LoOut); end
            end
            if (Done === 1'b1) begin done_cnt++; done_cyc = c; hi_s = HiOut; lo_s = LoOut; end
            step();
        end
        checks++; if (done_cnt !== 1 || done_cyc !== 46) begin failures++; $display("FAIL flush_restart got cnt=%0d cyc=%0d exp 1/46", done_cnt, done_cyc); end
        checks++; if (hi_s !== 32'd2 || lo_s !== 32'd14) begin failures++; $display("FAIL flush_restart_result got hi=%h lo=%h exp 2/e", hi_s, lo_s); end
    endtask

    task automatic test_back_to_back();
        int done_cnt = 0;
        logic [WIDTH-1:0] hi_s = '0, lo_s = '0;
        step();
        HiLoRead = 1'b1;
        #1;
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL idle_read_stall got %b exp 0", Stall); end
        HiLoRead = 1'b0;
        Start = 1'b1; Op = OP_MULTU; OperandA = 32'd3; OperandB = 32'd5;
        for (int c = 0; c < 75; c++) begin
            if (c == 1) Start = 1'b0;
            if (c == 5) HiLoRead = 1'b1;
            if (c == 6) begin HiLoRead = 1'b0; Start = 1'b1; Op = OP_DIVU; OperandA = 32'd20; OperandB = 32'd3; end
            if (c == 36) Start = 1'b0;
            @(negedge Clk);
            if (c == 5) begin
                checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL calc_read_stall got %b exp 1", Stall); end
            end
            if (c == 6) begin
                checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL calc_start_stall got %b exp 1", Stall); end
            end
            if (c == 35) begin
                checks++; if (Done !== 1'b1 || HiOut !== 32'd0 || LoOut !== 32'd15 || Stall !== 1'b0) begin failures++; $display("FAIL b2b_first got done=%b %h/%h stall=%b exp 1 0/f 0", Done, HiOut, LoOut, Stall); end
            end
            if (c == 36) begin
                checks++; if (Busy !== 1'b1 || Done !== 1'b0) begin failures++; $display("FAIL b2b_prep got busy=%b done=%b exp 1/0", Busy, Done); end
            end
            if (c == 70) begin hi_s = HiOut; lo_s = LoOut; end
            if (Done === 1'b1) done_cnt++;
            if (c == 70) begin
                checks++; if (Done !== 1'b1 || hi_s !== 32'd2 || lo_s !== 32'd6) begin failures++; $display("FAIL b2b_second got done=%b %h/%h exp 1 2/6", Done, hi_s, lo_s); end
            end
            step();
        end
        checks++; if (done_cnt !== 2) begin failures++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0;
        step();
        Start = 1'b1; Op = OP_MULT; OperandA = 32'd9; OperandB = 32'd9;
        for (int c = 0; c < 45; c++) begin
            if (c == 1)  Start = 1'b0;
            if (c == 10) Reset = 1'b0;
            if (c == 11) Reset = 1'b1;
            @(negedge Clk);
            if (c == 11) begin
                checks++; if (Busy !== 1'b0 || Done !== 1'b0 || DivByZero !== 1'b0) begin failures++; $display("FAIL midreset_ctrl got busy=%b done=%b dbz=%b exp 0/0/0", Busy, Done, DivByZero); end
                checks++; if (HiOut !== 32'h0 || LoOut !== 32'h0) begin failures++; $display("FAIL midreset_hilo got %h/%h exp 0/0", HiOut, LoOut); end
            end
            if (Done === 1'b1) done_cnt++;
            step();
        end
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL midreset_no_done got %0d exp 0", done_cnt); end
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; Flush = 1'b0; HiLoRead = 1'b0;
        Op = OP_MULT; OperandA = '0; OperandB = '0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
